fft_bitrev_loader: RTL

Input reordering stage that sits directly upstream of the FFT butterfly core. It accepts a frame of N = 2^LOG2N complex samples in natural order and stores each one at the bit-reversed address of its 4-bit index counter. It then delivers the frame in linear order, so the butterflies receive decimation-in-time ordered data. The block is single-buffered: it alternates between a FILL phase and a DRAIN phase.

---
 rtl/fft_bitrev_loader.sv | 81 ++++++++
 1 files changed

// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader: single-buffered frame reorder that fills at bit-reversed
// addresses and drains linearly, giving decimation-in-time order to the FFT core.
module fft_bitrev_loader #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last,
    output logic              frame_done
);
    localparam int N = 1 << LOG2N;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t              state, state_next;
    logic [LOG2N:0]      wr_cnt, rd_cnt, wr_next, rd_next, wr_inc, rd_inc;
    logic [LOG2N-1:0]    wr_addr;
    logic [2*DATA_W-1:0] mem [N];
    logic                accept, xfer, frame_done_next;

    assign in_ready  = (state == FILL) && !reset;
    assign out_valid = (state == DRAIN);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    // The carry into the counter MSB marks the final index of the frame.
    assign wr_inc    = wr_cnt + 1'b1;
    assign rd_inc    = rd_cnt + 1'b1;
    assign out_idx   = rd_cnt[LOG2N-1:0];
    assign out_last  = out_valid && rd_inc[LOG2N];
    assign {out_re, out_im} = mem[out_idx];

    always_comb begin
        wr_addr = '0;
        for (int i = 0; i < LOG2N; i++) wr_addr[i] = wr_cnt[LOG2N-1-i];
    end

    always_comb begin
        state_next      = state;
        wr_next         = wr_cnt;
        rd_next         = rd_cnt;
        frame_done_next = 1'b0;
        if (accept) begin
            wr_next    = wr_inc[LOG2N] ? '0 : wr_inc;
            state_next = wr_inc[LOG2N] ? DRAIN : state;
        end
        if (xfer) begin
            rd_next         = out_last ? '0 : rd_inc;
            state_next      = out_last ? FILL : state_next;
            frame_done_next = out_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            wr_cnt     <= wr_next;
            rd_cnt     <= rd_next;
            frame_done <= frame_done_next;
        end
    end

    // Sample storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_addr] <= {in_re, in_im};
    end
endmodule
